// File: rtl/pipeline_vertex_feeder.sv
// Vertex feeder for the transform pipeline: shadow/active config, vertex FIFO, launch, result capture FIFO.
// Latency: vertex accepted at edge t launches at t+1; its result is captured PIPE_LATENCY edges after launch.
// Backpressure: vtx_ready=!full; launches gated by result credit; macro PIPE_FEEDER_EXC_DROP_EN drops excepted results.
module pipeline_vertex_feeder #(
  parameter int VTX_DEPTH    = 8,
  parameter int RES_DEPTH    = 8,
  parameter int PIPE_LATENCY = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [15:0]  cfg_wdata,
  input  logic         cfg_commit,
  output logic         cfg_busy,
  input  logic         vtx_valid,
  output logic         vtx_ready,
  input  logic [15:0]  vtx_x,
  input  logic [15:0]  vtx_y,
  input  logic [15:0]  vtx_z,
  output logic [255:0] pipe_cfg,
  output logic         pipe_vld,
  output logic [15:0]  pipe_vx,
  output logic [15:0]  pipe_vy,
  output logic [15:0]  pipe_vz,
  input  logic [15:0]  res_x,
  input  logic [15:0]  res_y,
  input  logic [15:0]  res_exc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_x,
  output logic [15:0]  out_y,
  output logic [15:0]  out_exc,
  output logic [15:0]  exc_count
);
  localparam int VAW = $clog2(VTX_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam logic [VAW:0]   VTX_FULL = (VAW+1)'(VTX_DEPTH);
  localparam logic [RAW+1:0] RES_LIM  = (RAW+2)'(RES_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, UPDATE} feederState_t;

  feederState_t state, stateNext;
  logic [15:0] shadowCfg [16];
  logic [15:0] activeCfg [16];
  logic [VAW:0] vtxCount;
  logic [47:0]  vtxHead;
  logic [RAW:0] resCount;
  logic [RAW:0] inflight;
  logic [47:0]  resHead;
  logic [PIPE_LATENCY-1:0] launchSr;
  logic vtxPush, launch, capture, resPush, resPop, hasCredit;

  // Q8.8 identity: cosines and scales are 1.0, everything else 0.
  function automatic logic [15:0] cfgResetVal(input int idx);
    return (idx inside {4, 5, 6, 10, 11, 12}) ? 16'h0100 : 16'h0000;
  endfunction

  assign vtx_ready = (vtxCount != VTX_FULL);
  assign vtxPush   = vtx_valid && vtx_ready;
  // Reserve a result slot for every launch so a capture never finds the result FIFO full.
  assign hasCredit = ({1'b0, resCount} + {1'b0, inflight}) < RES_LIM;
  // A launch in the commit cycle would run with the old config, so the commit blocks it.
  assign launch    = (state == RUN) && !cfg_commit && (vtxCount != '0) && hasCredit;
  assign capture   = launchSr[PIPE_LATENCY-1];
  assign pipe_vld  = launchSr[0];
  assign out_valid = (resCount != '0);
  assign resPop    = out_valid && out_ready;
  assign out_x     = resHead[47:32];
  assign out_y     = resHead[31:16];
  assign out_exc   = resHead[15:0];

`ifdef PIPE_FEEDER_EXC_DROP_EN
  assign resPush = capture && (res_exc == 16'h0000);

  // Count dropped exception results, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_count <= 16'h0000;
    end else if (capture && (res_exc != 16'h0000) && (exc_count != 16'hFFFF)) begin
      exc_count <= exc_count + 16'h0001;
    end
  end
`else
  assign resPush   = capture;
  assign exc_count = 16'h0000;
`endif

  for (genvar g = 0; g < 16; g++) begin : gCfg
    assign pipe_cfg[16*g +: 16] = activeCfg[g];
  end

  // Shadow takes writes in any state; active copies shadow only in UPDATE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        shadowCfg[i] <= cfgResetVal(i);
        activeCfg[i] <= cfgResetVal(i);
      end
    end else begin
      if (cfg_we) shadowCfg[cfg_addr] <= cfg_wdata;
      if (state == UPDATE) begin
        for (int i = 0; i < 16; i++) activeCfg[i] <= shadowCfg[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= stateNext;
  end

  // FSM next state: drain in-flight work before swapping config.
  always_comb begin
    stateNext = state;
    cfg_busy  = 1'b0;
    case (state)
      RUN:    if (cfg_commit) stateNext = DRAIN;
      DRAIN:  begin
        cfg_busy = 1'b1;
        if (inflight == '0) stateNext = UPDATE;
      end
      UPDATE: begin
        cfg_busy  = 1'b1;
        stateNext = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  // Launch register, launch-tracking shift register and in-flight count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      launchSr <= '0;
      inflight <= '0;
      pipe_vx  <= 16'h0000;
      pipe_vy  <= 16'h0000;
      pipe_vz  <= 16'h0000;
    end else begin
      launchSr[0] <= launch;
      for (int i = 1; i < PIPE_LATENCY; i++) launchSr[i] <= launchSr[i-1];
      if (launch) begin
        pipe_vx <= vtxHead[47:32];
        pipe_vy <= vtxHead[31:16];
        pipe_vz <= vtxHead[15:0];
      end
      case ({launch, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  syncFifo #(.WIDTH(48), .DEPTH(VTX_DEPTH)) uVtxFifo (
    .clk(clk), .rst_n(rst_n),
    .push(vtxPush), .pushData({vtx_x, vtx_y, vtx_z}),
    .pop(launch), .popData(vtxHead), .count(vtxCount)
  );

  syncFifo #(.WIDTH(48), .DEPTH(RES_DEPTH)) uResFifo (
    .clk(clk), .rst_n(rst_n),
    .push(resPush), .pushData({res_x, res_y, res_exc}),
    .pop(resPop), .popData(resHead), .count(resCount)
  );
endmodule

// Generic synchronous FIFO, power-of-two depth, head visible on popData.
// Latency: a pushed word is readable the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller reads count.
module syncFifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;

  assign doPush  = push && (count != FULL_CNT);
  assign doPop   = pop && (count != '0);
  assign popData = mem[rdPtr];

  // Storage write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_vertex_feeder.sv
// Directed bench for pipeline_vertex_feeder with a fixed-latency pipeline model.
// Latency: model returns x+0x0101, y+0x0202, exc=1 when z==0xEEEE, six cycles after launch.
// Backpressure: out_ready toggled by the directed sequences to exercise credit and FIFO-full paths.
module tb_pipeline_vertex_feeder;
  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we, cfg_commit, cfg_busy;
  logic [3:0]   cfg_addr;
  logic [15:0]  cfg_wdata;
  logic         vtx_valid, vtx_ready;
  logic [15:0]  vtx_x, vtx_y, vtx_z;
  logic [255:0] pipe_cfg;
  logic         pipe_vld;
  logic [15:0]  pipe_vx, pipe_vy, pipe_vz;
  logic [15:0]  res_x, res_y, res_exc;
  logic         out_valid, out_ready;
  logic [15:0]  out_x, out_y, out_exc, exc_count;

  int checks = 0;
  int failures = 0;
  int launchCnt = 0;
  int busyLaunch = 0;
  logic [15:0] launchTx [$];
  logic [47:0] rxQ [$];

  bit          lineV [LAT];
  logic [15:0] lineX [LAT];
  logic [15:0] lineY [LAT];
  logic [15:0] lineZ [LAT];

  always #5 clk = ~clk;

  pipeline_vertex_feeder #(.VTX_DEPTH(8), .RES_DEPTH(8), .PIPE_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
    .pipe_cfg(pipe_cfg), .pipe_vld(pipe_vld),
    .pipe_vx(pipe_vx), .pipe_vy(pipe_vy), .pipe_vz(pipe_vz),
    .res_x(res_x), .res_y(res_y), .res_exc(res_exc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_exc(out_exc),
    .exc_count(exc_count)
  );

  // Pipeline model: delay line sampled mid-cycle, result driven before the capture edge.
  always @(negedge clk) begin
    for (int i = LAT-1; i > 0; i--) begin
      lineV[i] = lineV[i-1];
      lineX[i] = lineX[i-1];
      lineY[i] = lineY[i-1];
      lineZ[i] = lineZ[i-1];
    end
    lineV[0] = (pipe_vld === 1'b1);
    lineX[0] = pipe_vx;
    lineY[0] = pipe_vy;
    lineZ[0] = pipe_vz;
    if (lineV[LAT-1]) begin
      res_x   = lineX[LAT-1] + 16'h0101;
      res_y   = lineY[LAT-1] + 16'h0202;
      res_exc = (lineZ[LAT-1] == 16'hEEEE) ? 16'h0001 : 16'h0000;
    end else begin
      res_x   = 16'hDEAD;
      res_y   = 16'hBEEF;
      res_exc = 16'h0000;
    end
  end

  // Launch and output monitor.
  always @(negedge clk) begin
    if (pipe_vld === 1'b1) begin
      launchCnt++;
      launchTx.push_back(pipe_cfg[223:208]);
      if (cfg_busy) busyLaunch++;
    end
    if (out_valid === 1'b1 && out_ready) rxQ.push_back({out_x, out_y, out_exc});
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushVtx(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    int n = 0;
    vtx_valid = 1'b1;
    vtx_x = x;
    vtx_y = y;
    vtx_z = z;
    while (!vtx_ready && n < 100) begin
      step();
      n++;
    end
    checkVal("push_accept", 64'(vtx_ready), 64'd1);
    step();
    vtx_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (cfg_busy && n < 60) begin
      step();
      n++;
    end
    checkVal(tag, 64'(cfg_busy), 64'd0);
  endtask

  function automatic logic [47:0] expRes(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {x + 16'h0101, y + 16'h0202, (z == 16'hEEEE) ? 16'h0001 : 16'h0000};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic early;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 16'h0; cfg_commit = 1'b0;
    vtx_valid = 1'b0; vtx_x = 16'h0; vtx_y = 16'h0; vtx_z = 16'h0; out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    checkVal("rst_cosRoll", 64'(pipe_cfg[79:64]), 64'h0100);
    checkVal("rst_scaleX", 64'(pipe_cfg[175:160]), 64'h0100);
    checkVal("rst_camVerX", 64'(pipe_cfg[15:0]), 64'h0);
    checkVal("rst_transX", 64'(pipe_cfg[223:208]), 64'h0);
    checkVal("rst_out_valid", 64'(out_valid), 64'd0);
    checkVal("rst_vtx_ready", 64'(vtx_ready), 64'd1);
    checkVal("rst_cfg_busy", 64'(cfg_busy), 64'd0);
    checkVal("rst_pipe_vld", 64'(pipe_vld), 64'd0);
    checkVal("rst_exc_count", 64'(exc_count), 64'd0);

    // Single vertex: accepted at edge 0, launched edge 1, captured edge 7
    pushVtx(16'h0010, 16'h0020, 16'h0030);
    checkVal("t2_notYet", 64'(pipe_vld), 64'd0);
    step();
    checkVal("t2_launch", {63'd0, pipe_vld}, 64'd1);
    checkVal("t2_vx", 64'(pipe_vx), 64'h0010);
    checkVal("t2_vy", 64'(pipe_vy), 64'h0020);
    checkVal("t2_vz", 64'(pipe_vz), 64'h0030);
    step();
    checkVal("t2_oneLaunch", 64'(pipe_vld), 64'd0);
    repeat (4) step();
    checkVal("t2_outEarly", 64'(out_valid), 64'd0);
    step();
    checkVal("t2_outValid", 64'(out_valid), 64'd1);
    checkVal("t2_outX", 64'(out_x), 64'h0111);
    checkVal("t2_outY", 64'(out_y), 64'h0222);
    checkVal("t2_outExc", 64'(out_exc), 64'h0000);
    step();
    checkVal("t2_holdX", 64'(out_x), 64'h0111);
    out_ready = 1'b1;
    step();
    checkVal("t2_popped", 64'(out_valid), 64'd0);

    // Backpressure: result FIFO credit limits launches to 8
    rxQ.delete();
    launchCnt = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) pushVtx(16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300 + 16'(i));
    repeat (20) step();
    checkVal("t3_creditLaunches", 64'(launchCnt), 64'd8);
    checkVal("t3_stalled", 64'(pipe_vld), 64'd0);
    checkVal("t3_outValid", 64'(out_valid), 64'd1);
    checkVal("t3_vtxNotEmpty", 64'(vtx_ready), 64'd1);
    out_ready = 1'b1;
    repeat (40) step();
    checkVal("t3_allLaunches", 64'(launchCnt), 64'd12);
    checkVal("t3_rxCount", 64'(rxQ.size()), 64'd12);
    for (int i = 0; i < 12 && i < rxQ.size(); i++)
      checkVal("t3_order", 64'(rxQ[i]), 64'(expRes(16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300 + 16'(i))));

    // Commit while three vertices are in flight
    rxQ.delete();
    launchTx.delete();
    launchCnt = 0;
    busyLaunch = 0;
    cfg_we = 1'b1; cfg_addr = 4'd13; cfg_wdata = 16'h0500;
    step();
    cfg_we = 1'b0;
    checkVal("t4_shadowHidden", 64'(pipe_cfg[223:208]), 64'h0);
    for (int i = 0; i < 3; i++) pushVtx(16'h0600 + 16'(i), 16'h0610, 16'h0620);
    step();
    cfg_commit = 1'b1;
    pushVtx(16'h0603, 16'h0610, 16'h0620);
    cfg_commit = 1'b0;
    checkVal("t4_busy", 64'(cfg_busy), 64'd1);
    pushVtx(16'h0604, 16'h0610, 16'h0620);
    pushVtx(16'h0605, 16'h0610, 16'h0620);
    early = 1'b0;
    n = 0;
    while (cfg_busy && n < 60) begin
      if (pipe_cfg[223:208] != 16'h0) early = 1'b1;
      step();
      n++;
    end
    checkVal("t4_busyFalls", 64'(cfg_busy), 64'd0);
    checkVal("t4_newTransX", 64'(pipe_cfg[223:208]), 64'h0500);
    checkVal("t4_noEarlyCfg", 64'(early), 64'd0);
    repeat (20) step();
    checkVal("t4_noBusyLaunch", 64'(busyLaunch), 64'd0);
    checkVal("t4_launches", 64'(launchCnt), 64'd6);
    for (int i = 0; i < 6 && i < launchTx.size(); i++)
      checkVal("t4_launchCfg", 64'(launchTx[i]), (i < 3) ? 64'h0 : 64'h0500);
    checkVal("t4_rxCount", 64'(rxQ.size()), 64'd6);

    // Exception on the second of four vertices
    rxQ.delete();
    pushVtx(16'h0700, 16'h0710, 16'h0720);
    pushVtx(16'h0701, 16'h0711, 16'hEEEE);
    pushVtx(16'h0702, 16'h0712, 16'h0722);
    pushVtx(16'h0703, 16'h0713, 16'h0723);
    repeat (20) step();
`ifdef PIPE_FEEDER_EXC_DROP_EN
    checkVal("t5_rxCount", 64'(rxQ.size()), 64'd3);
    checkVal("t5_excCount", 64'(exc_count), 64'd1);
    if (rxQ.size() > 1) checkVal("t5_skip", 64'(rxQ[1]), 64'(expRes(16'h0702, 16'h0712, 16'h0722)));
`else
    checkVal("t5_rxCount", 64'(rxQ.size()), 64'd4);
    checkVal("t5_excCount", 64'(exc_count), 64'd0);
    if (rxQ.size() > 1) checkVal("t5_kept", 64'(rxQ[1]), 64'(expRes(16'h0701, 16'h0711, 16'hEEEE)));
`endif

    // Vertex FIFO full while launches are held; write and commit in the same cycle
    rxQ.delete();
    launchCnt = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pushVtx(16'h0800 + 16'(i), 16'h0810, 16'h0820);
    step();
    cfg_we = 1'b1; cfg_addr = 4'd14; cfg_wdata = 16'h0700; cfg_commit = 1'b1;
    step();
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    checkVal("t6_busy", 64'(cfg_busy), 64'd1);
    for (int i = 0; i < 8; i++) pushVtx(16'h0900 + 16'(i), 16'h0910, 16'h0920);
    checkVal("t6_full", 64'(vtx_ready), 64'd0);
    vtx_valid = 1'b1; vtx_x = 16'h0999; vtx_y = 16'h0999; vtx_z = 16'h0999;
    step();
    vtx_valid = 1'b0;
    checkVal("t6_stillFull", 64'(vtx_ready), 64'd0);
    waitIdle("t6_busyFalls");
    checkVal("t6_sameCycleWrite", 64'(pipe_cfg[239:224]), 64'h0700);
    checkVal("t6_heldLaunches", 64'(launchCnt), 64'd8);
    out_ready = 1'b1;
    n = 0;
    while (!pipe_vld && n < 30) begin
      step();
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      checkVal("t6_burst", 64'({pipe_vld, pipe_vx}), 64'({1'b1, 16'h0900 + 16'(i)}));
      step();
    end
    checkVal("t6_ninthDropped", 64'(pipe_vld), 64'd0);
    repeat (30) step();
    checkVal("t6_rxCount", 64'(rxQ.size()), 64'd16);
    for (int i = 0; i < 8 && (8 + i) < rxQ.size(); i++)
      checkVal("t6_order", 64'(rxQ[8+i]), 64'(expRes(16'h0900 + 16'(i), 16'h0910, 16'h0920)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_vertex_feeder.md
Name: pipeline_vertex_feeder

Overview:
Transmit-side driver for the graphics transform pipeline.
- Holds the transform configuration: camera vertex, camera distance, roll/pitch/yaw cos/sin, scale, translation.
- Buffers incoming vertices and launches them into the pipeline one per cycle.
- Captures outX/outY/outException after the fixed pipeline latency into a result FIFO with valid/ready output.
- Sits between the scene/vertex source and the pipeline; makes config updates safe by draining in-flight work first.

Parameters:
VTX_DEPTH, 8, vertex input FIFO depth (power of 2, >=2)
RES_DEPTH, 8, result FIFO depth (power of 2, >=2)
PIPE_LATENCY, 6, cycles from a launch to valid result at res_* (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  shadow config register write strobe
cfg_addr  in  4  register index: 0 camVerX, 1 camVerY, 2 camVerZ, 3 camDc, 4 cosRoll, 5 cosPitch, 6 cosYaw, 7 senRoll, 8 senPitch, 9 senYaw, 10-12 scaleX/Y/Z, 13-15 transX/Y/Z
cfg_wdata  in  16  write data
cfg_commit  in  1  pulse: apply shadow config to active
cfg_busy  out  1  commit pending or in progress
vtx_valid  in  1  input vertex valid
vtx_ready  out  1  vertex FIFO not full
vtx_x, vtx_y, vtx_z  in  16 each  input vertex
pipe_cfg  out  256  active config; register i at [16i+15:16i]
pipe_vld  out  1  launch strobe (one vertex per high cycle)
pipe_vx, pipe_vy, pipe_vz  out  16 each  launched vertex (vertexX/Y/Z)
res_x, res_y, res_exc  in  16 each  pipeline outX, outY, outException
out_valid  out  1  result FIFO not empty
out_ready  in  1  result consumer ready
out_x, out_y, out_exc  out  16 each  head of result FIFO
exc_count  out  16  dropped-exception counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge):
  - Both FIFOs empty; FSM RUN; in-flight count 0; launch shift register clear; pipe_vld=0; cfg_busy=0; exc_count=0.
  - Active and shadow config: Q8.8 values; cos*=0x0100 and scale*=0x0100; all others 0.
  - Reset mid-operation discards all in-flight launches; results arriving afterwards are ignored.
- Config write: cfg_we writes shadow[cfg_addr] at the clock edge, in any state. Shadow is never visible on pipe_cfg until a commit.
- FSM:
  - RUN: launches allowed. cfg_commit -> DRAIN and cfg_busy=1.
  - DRAIN: no launches. When in-flight==0 -> UPDATE.
  - UPDATE: one cycle; active<=shadow; cfg_busy=0 next cycle; -> RUN.
  - cfg_commit outside RUN is ignored.
  - cfg_we and cfg_commit in the same cycle: the write lands in shadow before the copy.
- Launch: registered. In RUN, pipe_vld=1 next cycle when all hold:
  - vertex FIFO non-empty;
  - credit = RES_DEPTH - res_count - inflight > 0.
  - pipe_vx/vy/vz then carry the popped vertex.
  - Otherwise pipe_vld=0 and pipe_v* hold their last value.
- Vertex latency: a vertex accepted at edge t can launch at earliest cycle t+1, i.e. pipe_vld high in the cycle after acceptance.
- Capture:
  - A PIPE_LATENCY-deep shift register tracks launches.
  - res_* is sampled at the edge PIPE_LATENCY cycles after the pipe_vld-high cycle and pushed to the result FIFO.
  - out_valid rises the following cycle.
  - Credit rule guarantees a push never meets a full result FIFO; no overflow path exists.
- In-flight counter: +1 on launch, -1 on capture. Both in one cycle leaves it unchanged.
- FIFOs:
  - vtx_ready = !full; push and pop in the same cycle are allowed when full or empty per normal FIFO rules.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - Pointers wrap modulo depth.
- exc_count saturates at 0xFFFF.

Optional Feature:
PIPE_FEEDER_EXC_DROP_EN
- Defined: captured results with res_exc != 0 are not pushed. They still release in-flight/credit, and exc_count increments by 1 (saturating).
- Undefined: every result is pushed regardless of res_exc; exc_count is constant 0.

Test Plan:
- Reset config: reset then idle -> pipe_cfg bits [79:64]=0x0100, [175:160]=0x0100, [15:0]=0; out_valid=0; vtx_ready=1.
- Single vertex, PIPE_LATENCY=6: vertex (0x0010,0x0020,0x0030) accepted at edge 0.
  - pipe_vld=1 in cycle 1 with those values.
  - Model returns res_x=0x0111, res_y=0x0222, res_exc=0 at edge 7.
  - out_valid=1 in cycle 8 with those values.
- Backpressure, RES_DEPTH=8, out_ready=0: 12 vertices pushed -> exactly 8 launches, then pipe_vld stays 0 with 4 vertices still in FIFO.
  - Raise out_ready -> remaining 4 launch.
  - 12 results come out in order.
- Commit during streaming: write cfg_addr=13 data 0x0500, then cfg_commit while 3 in flight.
  - No launch until in-flight=0.
  - pipe_cfg[223:208]=0x0500 one cycle after drain; cfg_busy falls.
  - No vertex launched after the commit sees the old config.
- Exception drop with PIPE_FEEDER_EXC_DROP_EN: 4 vertices, model sets res_exc=0x0001 on the 2nd -> 3 results out, exc_count=1.
  - Without the macro: 4 results out, exc_count=0.
- Vertex FIFO full: VTX_DEPTH=8 in DRAIN, push 8 -> vtx_ready=0; a 9th vtx_valid is not accepted.
  - After commit completes, all 8 launch on consecutive cycles.
